// File: rtl/instruction_fetch_pkg.sv
// Shared fetch types: state encoding, buffer entry layout and datapath constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package instruction_fetch_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam logic [31:0] FETCH_WORD_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        FETCH_STATE_FETCH   = 2'd0,
        FETCH_STATE_DISCARD = 2'd1,
        FETCH_STATE_FAULT   = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]                  addr;
        logic [INSTRUCTION_WIDTH-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO of {address, word}; head_o is entry 0.
// Latency: a pushed entry is visible on head_o the cycle after the push.
// Backpressure: pushes into a full buffer without a same-cycle pop are dropped; clear wins.
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  fetch_entry_t push_entry_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry0_q, entry0_d;
    fetch_entry_t entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    logic         do_push;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            // Pop shifts first so a simultaneous push lands behind the survivor.
            if (do_pop) begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            if (do_push) begin
                if (count_d == 2'd0) begin
                    entry0_d = push_entry_i;
                end else begin
                    entry1_d = push_entry_i;
                end
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entry0_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: one-outstanding word reads into a 2-entry buffer presented to decode.
// Latency: ack to currentInstruction 1 cycle; redirect to new request 1 cycle.
// Backpressure: stall holds the head; no request when full. INSTRUCTION_FETCH_ALIGN_CHECK_EN adds misaligned-redirect faults.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
    parameter int          BUFFER_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [31:0]                  redirectAddress,
    output logic                         fetchRequest,
    output logic [31:0]                  fetchAddress,
    input  logic                         fetchAck,
    input  logic [INSTRUCTION_WIDTH-1:0] fetchData,
    output logic [INSTRUCTION_WIDTH-1:0] currentInstruction,
    output logic [31:0]                  currentAddress,
    output logic                         isNOP,
    output logic                         fetchFault
);

    if (BUFFER_DEPTH != 2) begin : g_depth_check
        $error("instruction_fetch: BUFFER_DEPTH must be 2");
    end

    fetch_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  target_q, target_d;
    logic         fault_pend_q, fault_pend_d;

    logic [1:0]   count;
    logic [1:0]   count_after;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         hold;
    logic         accept_ack;
    logic         push;
    logic         pop;
    logic         misaligned;
    logic [31:0]  target;

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    assign target     = redirectAddress;
    assign misaligned = |redirectAddress[1:0];
`else
    assign target     = redirectAddress & ~32'h3;
    assign misaligned = 1'b0;
`endif

    assign hold        = req_q && !fetchAck;
    assign accept_ack  = req_q && fetchAck;
    assign push        = accept_ack && (state_q == FETCH_STATE_FETCH) && !redirect;
    assign pop         = (count != 2'd0) && !stall && !redirect && (state_q == FETCH_STATE_FETCH);
    assign count_after = redirect ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
    assign push_entry  = '{addr: addr_q, word: fetchData};

    fetch_buffer u_fetch_buffer (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push),
        .pop_i        (pop),
        .clear_i      (redirect),
        .push_entry_i (push_entry),
        .count_o      (count),
        .head_o       (head)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        target_d     = target_q;
        fault_pend_d = fault_pend_q;
        case (state_q)
            FETCH_STATE_FETCH: begin
                if (redirect) begin
                    if (hold) begin
                        state_d      = FETCH_STATE_DISCARD;
                        target_d     = target;
                        fault_pend_d = misaligned;
                    end else if (misaligned) begin
                        state_d = FETCH_STATE_FAULT;
                        req_d   = 1'b0;
                    end else begin
                        addr_d = target;
                        req_d  = enable;
                    end
                end else if (!hold) begin
                    if (accept_ack) begin
                        addr_d = addr_q + FETCH_WORD_STRIDE;
                    end
                    // Gate on post-edge occupancy so the single outstanding read always has a slot.
                    req_d = enable && (count_after < 2'd2);
                end
            end
            FETCH_STATE_DISCARD: begin
                if (redirect) begin
                    target_d     = target;
                    fault_pend_d = misaligned;
                end
                if (!hold) begin
                    if (fault_pend_d) begin
                        state_d = FETCH_STATE_FAULT;
                        req_d   = 1'b0;
                    end else begin
                        state_d = FETCH_STATE_FETCH;
                        addr_d  = target_d;
                        req_d   = enable;
                    end
                end
            end
            FETCH_STATE_FAULT: begin
                req_d = 1'b0;
                if (redirect && !misaligned) begin
                    state_d = FETCH_STATE_FETCH;
                    addr_d  = target;
                    req_d   = enable;
                end
            end
            default: begin
                state_d = FETCH_STATE_FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_STATE_FETCH;
            req_q        <= 1'b0;
            addr_q       <= RESET_ADDRESS;
            target_q     <= '0;
            fault_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            target_q     <= target_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    assign fetchRequest       = req_q;
    assign fetchAddress       = addr_q;
    assign isNOP              = (count == 2'd0) || (state_q != FETCH_STATE_FETCH);
    assign currentInstruction = isNOP ? '0 : head.word;
    assign currentAddress     = isNOP ? '0 : head.addr;

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    assign fetchFault = (state_q == FETCH_STATE_FAULT);
`else
    assign fetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; a small memory responder acks after a programmable latency.
module tb_instruction_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectAddress;
    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic        fetchAck;
    logic [31:0] fetchData;
    logic [31:0] currentInstruction;
    logic [31:0] currentAddress;
    logic        isNOP;
    logic        fetchFault;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat    = 0;
    int wait_cnt = 0;

    instruction_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .stall              (stall),
        .redirect           (redirect),
        .redirectAddress    (redirectAddress),
        .fetchRequest       (fetchRequest),
        .fetchAddress       (fetchAddress),
        .fetchAck           (fetchAck),
        .fetchData          (fetchData),
        .currentInstruction (currentInstruction),
        .currentAddress     (currentAddress),
        .isNOP              (isNOP),
        .fetchFault         (fetchFault)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive this cycle's memory response, then advance one clock.
    task automatic tick();
        if (fetchRequest) begin
            if (wait_cnt >= lat) begin
                fetchAck  = 1'b1;
                fetchData = fetchAddress ^ KEY;
                wait_cnt  = 0;
            end else begin
                fetchAck  = 1'b0;
                wait_cnt  = wait_cnt + 1;
            end
        end else begin
            fetchAck = 1'b0;
            wait_cnt = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirectAddress = '0; fetchAck = 1'b0; fetchData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",   {31'd0, fetchRequest}, 32'd0);
        check("rst_addr",  fetchAddress,          32'h0);
        check("rst_nop",   {31'd0, isNOP},        32'd1);
        check("rst_instr", currentInstruction,    32'h0);
        check("rst_caddr", currentAddress,        32'h0);
        check("rst_fault", {31'd0, fetchFault},   32'd0);

        rst = 1'b0;
        tick();
        check("first_req",  {31'd0, fetchRequest}, 32'd1);
        check("first_addr", fetchAddress,          32'h0);
        tick();
        check("w0_nop",   {31'd0, isNOP},     32'd0);
        check("w0_instr", currentInstruction, 32'hA5A5_A5A5);
        check("w0_caddr", currentAddress,     32'h0);
        check("w0_faddr", fetchAddress,       32'h4);
        tick();
        check("w1_instr", currentInstruction, 32'hA5A5_A5A1);
        check("w1_faddr", fetchAddress,       32'h8);

        // Stall until the buffer fills (head @4, tail @8).
        stall = 1'b1;
        tick();
        check("full_req",   {31'd0, fetchRequest}, 32'd0);
        check("full_caddr", currentAddress,        32'h4);
        repeat (4) tick();
        check("stall_req",   {31'd0, fetchRequest}, 32'd0);
        check("stall_caddr", currentAddress,        32'h4);
        stall = 1'b0;
        tick();
        check("rel_caddr", currentAddress,        32'h8);
        check("rel_instr", currentInstruction,    32'hA5A5_A5AD);
        check("rel_req",   {31'd0, fetchRequest}, 32'd1);
        check("rel_faddr", fetchAddress,          32'hC);
        tick();
        check("rel2_caddr", currentAddress,     32'hC);
        check("rel2_instr", currentInstruction, 32'hA5A5_A5A9);

        // Three-cycle acks; redirect while the read of 0x10 is outstanding.
        lat = 3;
        tick();
        check("slow_nop", {31'd0, isNOP}, 32'd1);
        redirect = 1'b1; redirectAddress = 32'h0000_1000;
        tick();
        redirect = 1'b0;
        check("disc_faddr", fetchAddress,          32'h10);
        check("disc_req",   {31'd0, fetchRequest}, 32'd1);
        check("disc_nop",   {31'd0, isNOP},        32'd1);
        tick();
        check("disc_nop2", {31'd0, isNOP}, 32'd1);
        tick();
        check("tgt_faddr", fetchAddress,          32'h1000);
        check("tgt_req",   {31'd0, fetchRequest}, 32'd1);
        check("tgt_nop",   {31'd0, isNOP},        32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tgt_wait_nop", {31'd0, isNOP}, 32'd1);
        end
        tick();
        check("tgt_nop_lo", {31'd0, isNOP},     32'd0);
        check("tgt_caddr",  currentAddress,     32'h1000);
        check("tgt_instr",  currentInstruction, 32'hA5A5_B5A5);
        check("tgt_faddr2", fetchAddress,       32'h1004);

        // Redirect coinciding with the ack that would fill the stalled buffer.
        stall = 1'b1;
        repeat (3) tick();
        check("hold_caddr", currentAddress, 32'h1000);
        redirect = 1'b1; redirectAddress = 32'h0000_2000;
        tick();
        redirect = 1'b0;
        check("rack_nop",   {31'd0, isNOP},        32'd1);
        check("rack_faddr", fetchAddress,          32'h2000);
        check("rack_req",   {31'd0, fetchRequest}, 32'd1);

        // Fill the buffer, then redirect near the top of the address space.
        lat = 0;
        repeat (2) tick();
        check("full2_req",   {31'd0, fetchRequest}, 32'd0);
        check("full2_caddr", currentAddress,        32'h2000);
        redirect = 1'b1; redirectAddress = 32'hFFFF_FFF8; stall = 1'b0;
        tick();
        redirect = 1'b0;
        check("wrap_nop",   {31'd0, isNOP},        32'd1);
        check("wrap_faddr", fetchAddress,          32'hFFFF_FFF8);
        check("wrap_req",   {31'd0, fetchRequest}, 32'd1);
        tick();
        check("wrap0_caddr", currentAddress,     32'hFFFF_FFF8);
        check("wrap0_instr", currentInstruction, 32'h5A5A_5A5D);
        check("wrap0_faddr", fetchAddress,       32'hFFFF_FFFC);
        tick();
        check("wrap1_caddr", currentAddress,     32'hFFFF_FFFC);
        check("wrap1_instr", currentInstruction, 32'h5A5A_5A59);
        check("wrap1_faddr", fetchAddress,       32'h0);
        tick();
        check("wrap2_caddr", currentAddress,     32'h0);
        check("wrap2_instr", currentInstruction, 32'hA5A5_A5A5);
        check("wrap2_faddr", fetchAddress,       32'h4);

        // Disable: the outstanding read completes, nothing new is raised.
        enable = 1'b0;
        tick();
        check("dis_req",   {31'd0, fetchRequest}, 32'd0);
        check("dis_caddr", currentAddress,        32'h4);
        check("dis_faddr", fetchAddress,          32'h8);
        tick();
        check("dis_nop",  {31'd0, isNOP},        32'd1);
        check("dis_req2", {31'd0, fetchRequest}, 32'd0);
        enable = 1'b1;

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        redirect = 1'b1; redirectAddress = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check("flt_fault", {31'd0, fetchFault},   32'd1);
        check("flt_req",   {31'd0, fetchRequest}, 32'd0);
        check("flt_nop",   {31'd0, isNOP},        32'd1);
        repeat (3) tick();
        check("flt_req2",   {31'd0, fetchRequest}, 32'd0);
        check("flt_fault2", {31'd0, fetchFault},   32'd1);
        redirect = 1'b1; redirectAddress = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check("unflt_fault", {31'd0, fetchFault},   32'd0);
        check("unflt_faddr", fetchAddress,          32'h200);
        check("unflt_req",   {31'd0, fetchRequest}, 32'd1);
        tick();
        check("unflt_caddr", currentAddress,     32'h200);
        check("unflt_instr", currentInstruction, 32'hA5A5_A7A5);
`else
        redirect = 1'b1; redirectAddress = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check("mis_fault", {31'd0, fetchFault},   32'd0);
        check("mis_faddr", fetchAddress,          32'h100);
        check("mis_req",   {31'd0, fetchRequest}, 32'd1);
        tick();
        check("mis_caddr", currentAddress,     32'h100);
        check("mis_instr", currentInstruction, 32'hA5A5_A4A5);
`endif

        // Reset with a live request and a coincident ack.
        rst = 1'b1;
        tick();
        check("rst2_req",   {31'd0, fetchRequest}, 32'd0);
        check("rst2_faddr", fetchAddress,          32'h0);
        check("rst2_nop",   {31'd0, isNOP},        32'd1);
        check("rst2_instr", currentInstruction,    32'h0);
        rst = 1'b0;
        tick();
        check("rst2_first_req",  {31'd0, fetchRequest}, 32'd1);
        check("rst2_first_addr", fetchAddress,          32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
